// File: rtl/tinyqv_uart_pkg.sv
// Shared constants and types for the TinyQV debug UART with TX FIFO.
package tinyqv_uart_pkg;

    localparam logic [3:0] REG_DATA    = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_DIVIDER = 4'h8;
    localparam logic [3:0] REG_CTRL    = 4'hC;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 8;

    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_THRESH_LSB  = 8;

    localparam int MIN_DIVIDER = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/tinyqv_sync_fifo.sv
// Synchronous power-of-two FIFO with occupancy count; pushes to a full FIFO
// and pops from an empty one are ignored.
module tinyqv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/tinyqv_debug_uart_fifo.sv
// TinyQV peripheral UART transmitter: byte FIFO, programmable baud divider,
// sticky overflow flag and a level-triggered FIFO-threshold interrupt.
module tinyqv_debug_uart_fifo
    import tinyqv_uart_pkg::*;
#(
    parameter int CLOCK_HZ     = 64_000_000,
    parameter int DEFAULT_BAUD = 115_200,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_WIDTH    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        uart_txd,
    output logic        interrupt
);

    localparam int CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int RAW_DIV     = CLOCK_HZ / DEFAULT_BAUD;
    localparam int RESET_DIV   = (RAW_DIV < MIN_DIVIDER) ? MIN_DIVIDER : RAW_DIV;

    logic                 wr_en;
    logic                 rd_en;
    logic                 sel_data;
    logic                 sel_status;
    logic                 sel_divider;
    logic                 sel_ctrl;

    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] wr_div;
    logic                 irq_en;
    logic [7:0]           threshold;
    logic                 overflow;
    logic                 irq_en_next;
    logic [7:0]           threshold_next;
    logic [CW-1:0]        count_next;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    tx_state_t            state;
    logic [7:0]           tx_shift;
    logic [2:0]           bit_idx;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [DIV_WIDTH-1:0] frame_div;
    logic                 baud_end;
    logic                 unused_ok;

    assign wr_en       = (data_write_n != 2'b11);
    assign rd_en       = (data_read_n != 2'b11);
    assign sel_data    = (addr_in[3:2] == REG_DATA[3:2]);
    assign sel_status  = (addr_in[3:2] == REG_STATUS[3:2]);
    assign sel_divider = (addr_in[3:2] == REG_DIVIDER[3:2]);
    assign sel_ctrl    = (addr_in[3:2] == REG_CTRL[3:2]);
    assign data_ready  = 1'b1;
    assign wr_div      = data_in[DIV_WIDTH-1:0];
    assign fifo_push   = wr_en && sel_data;
    assign baud_end    = (baud_cnt == frame_div - DIV_WIDTH'(1));
    assign unused_ok   = &{1'b0, addr_in[1:0], data_in[31:16]};

    tinyqv_sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .din  (data_in[7:0]),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            case (state)
                ST_IDLE: fifo_pop = 1'b1;
                ST_STOP: fifo_pop = baud_end;
                default: fifo_pop = 1'b0;
            endcase
        end
    end

    // The interrupt is computed from next-cycle register values so that it
    // changes together with STATUS rather than a cycle behind it.
    assign irq_en_next    = (wr_en && sel_ctrl) ? data_in[CTRL_IRQ_EN_BIT] : irq_en;
    assign threshold_next = (wr_en && sel_ctrl) ? data_in[CTRL_THRESH_LSB +: 8] : threshold;
    assign count_next     = fifo_count + CW'(fifo_push && !fifo_full) - CW'(fifo_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divider   <= DIV_WIDTH'(RESET_DIV);
            irq_en    <= 1'b0;
            threshold <= '0;
            overflow  <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            irq_en    <= irq_en_next;
            threshold <= threshold_next;
            interrupt <= irq_en_next && (32'(count_next) <= 32'(threshold_next));
            if (wr_en && sel_divider)
                divider <= (wr_div < DIV_WIDTH'(MIN_DIVIDER)) ? DIV_WIDTH'(MIN_DIVIDER) : wr_div;
            if (fifo_push && fifo_full)
                overflow <= 1'b1;
            else if (wr_en && sel_status && data_in[STATUS_OVF_BIT])
                overflow <= 1'b0;
        end
    end

    // Shifter: the divider is latched per frame, and STOP chains straight into
    // the next START when more data is queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_shift  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            frame_div <= DIV_WIDTH'(MIN_DIVIDER);
            uart_txd  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state     <= ST_START;
                        tx_shift  <= fifo_dout;
                        frame_div <= divider;
                        baud_cnt  <= '0;
                        uart_txd  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        state    <= ST_DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_txd <= tx_shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state    <= ST_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= tx_shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            state     <= ST_START;
                            tx_shift  <= fifo_dout;
                            frame_div <= divider;
                            uart_txd  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + DIV_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if (rd_en) begin
            if (sel_status) begin
                data_out[STATUS_BUSY_BIT]            = (state != ST_IDLE) || !fifo_empty;
                data_out[STATUS_FULL_BIT]            = fifo_full;
                data_out[STATUS_EMPTY_BIT]           = fifo_empty;
                data_out[STATUS_OVF_BIT]             = overflow;
                data_out[STATUS_COUNT_LSB +: CW]     = fifo_count;
            end else if (sel_divider) begin
                data_out[DIV_WIDTH-1:0] = divider;
            end else if (sel_ctrl) begin
                data_out[CTRL_IRQ_EN_BIT]        = irq_en;
                data_out[CTRL_THRESH_LSB +: 8]   = threshold;
            end
        end
    end

endmodule

// File: tb/tb_tinyqv_debug_uart_fifo.sv
// Directed self-checking bench for tinyqv_debug_uart_fifo with hand-derived
// serial frames, FIFO occupancy and interrupt expectations.
module tb_tinyqv_debug_uart_fifo;

    logic        clk;
    logic        rst;
    logic [3:0]  addr_in;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        uart_txd;
    logic        interrupt;

    int checks = 0;
    int errors = 0;

    tinyqv_debug_uart_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .data_write_n(data_write_n),
        .data_read_n (data_read_n),
        .data_out    (data_out),
        .data_ready  (data_ready),
        .uart_txd    (uart_txd),
        .interrupt   (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_in      = a;
        data_in      = d;
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic readReg(input logic [3:0] a, output logic [31:0] d);
        addr_in     = a;
        data_read_n = 2'b00;
        #1;
        d = data_out;
        data_read_n = 2'b11;
    endtask

    function automatic logic frameBit(input logic [7:0] b, input int slot);
        if (slot == 0)
            return 1'b0;
        else if (slot == 9)
            return 1'b1;
        else
            return b[slot-1];
    endfunction

    logic [31:0] rd;
    logic [7:0]  stream [17];
    logic [7:0]  byte_v;
    logic        saw_low;

    initial begin
        rst          = 1'b1;
        addr_in      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        readReg(4'h8, rd);
        checkOutput("reset_divider", rd, 32'd555);
        readReg(4'h4, rd);
        checkOutput("reset_status", rd, 32'h0000_0004);
        readReg(4'hC, rd);
        checkOutput("reset_ctrl", rd, 32'h0);
        readReg(4'h0, rd);
        checkOutput("data_reads_zero", rd, 32'h0);
        checkOutput("reset_txd", 32'(uart_txd), 32'd1);
        checkOutput("reset_irq", 32'(interrupt), 32'd0);
        checkOutput("data_ready", 32'(data_ready), 32'd1);

        // Single byte 0xA5 at divider 4
        applyStimulus(4'h8, 32'd4);
        readReg(4'h8, rd);
        checkOutput("divider_4", rd, 32'd4);
        applyStimulus(4'h0, 32'hA5);
        readReg(4'h4, rd);
        checkOutput("a5_count1", rd, 32'h0000_0101);
        checkOutput("a5_txd_pre", 32'(uart_txd), 32'd1);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k <= 40)
                checkOutput($sformatf("a5_txd_%0d", k), 32'(uart_txd), 32'(frameBit(8'hA5, (k - 1) / 4)));
            if (k == 40) begin
                readReg(4'h4, rd);
                checkOutput("a5_busy_last", 32'(rd[0]), 32'd1);
            end
            if (k == 41) begin
                readReg(4'h4, rd);
                checkOutput("a5_idle_status", rd, 32'h0000_0004);
                checkOutput("a5_txd_idle", 32'(uart_txd), 32'd1);
            end
        end

        // 17 back-to-back bytes: first one pops at once, stream is gap-free
        for (int i = 0; i < 17; i++)
            stream[i] = 8'(i * 37 + 5);
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    @(negedge clk);
                    addr_in      = 4'h0;
                    data_in      = 32'(stream[i]);
                    data_write_n = 2'b00;
                end
                @(negedge clk);
                data_write_n = 2'b11;
            end
            begin
                @(negedge clk);
                for (int k = 1; k <= 682; k++) begin
                    @(negedge clk);
                    if (k == 1) begin
                        checkOutput("burst_txd_pre", 32'(uart_txd), 32'd1);
                    end else if (k <= 681) begin
                        byte_v = stream[(k - 2) / 40];
                        checkOutput($sformatf("burst_txd_%0d", k), 32'(uart_txd),
                                    32'(frameBit(byte_v, ((k - 2) % 40) / 4)));
                    end else begin
                        checkOutput("burst_txd_end", 32'(uart_txd), 32'd1);
                    end
                    if (k == 17) begin
                        readReg(4'h4, rd);
                        checkOutput("burst_status_16", rd, 32'h0000_1003);
                    end
                end
            end
        join
        readReg(4'h4, rd);
        checkOutput("burst_done_status", rd, 32'h0000_0004);

        // Overflow with a stalled shifter
        applyStimulus(4'h8, 32'h0000_FFFF);
        readReg(4'h8, rd);
        checkOutput("divider_ffff", rd, 32'h0000_FFFF);
        for (int i = 0; i < 17; i++)
            applyStimulus(4'h0, 32'(8'h10 + i));
        readReg(4'h4, rd);
        checkOutput("fill_16", rd, 32'h0000_1003);
        applyStimulus(4'h0, 32'h77);
        readReg(4'h4, rd);
        checkOutput("overflow_set", rd, 32'h0000_100B);
        applyStimulus(4'h4, 32'h8);
        readReg(4'h4, rd);
        checkOutput("overflow_clr", rd, 32'h0000_1003);
        applyStimulus(4'h8, 32'd1);
        readReg(4'h8, rd);
        checkOutput("divider_clamp", rd, 32'd4);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        readReg(4'h4, rd);
        checkOutput("post_reset_status", rd, 32'h0000_0004);
        readReg(4'h8, rd);
        checkOutput("post_reset_divider", rd, 32'd555);

        // Threshold interrupt: 4 pushes leave 3 queued, irq fires at count 2
        applyStimulus(4'h8, 32'd4);
        applyStimulus(4'hC, 32'h0000_0201);
        readReg(4'hC, rd);
        checkOutput("ctrl_rb", rd, 32'h0000_0201);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr_in      = 4'h0;
            data_in      = 32'h0;
            data_write_n = 2'b00;
        end
        @(negedge clk);
        data_write_n = 2'b11;
        checkOutput("irq_after_push", 32'(interrupt), 32'd0);
        readReg(4'h4, rd);
        checkOutput("irq_count3", rd, 32'h0000_0301);
        for (int n = 1; n <= 38; n++) begin
            @(negedge clk);
            if (n < 38) begin
                checkOutput($sformatf("irq_low_%0d", n), 32'(interrupt), 32'd0);
            end else begin
                checkOutput("irq_high", 32'(interrupt), 32'd1);
                readReg(4'h4, rd);
                checkOutput("irq_count2", rd, 32'h0000_0201);
            end
        end

        // Asynchronous reset in the middle of a zero data bit
        repeat (10) @(negedge clk);
        checkOutput("pre_rst_txd_low", 32'(uart_txd), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_txd", 32'(uart_txd), 32'd1);
        checkOutput("async_rst_irq", 32'(interrupt), 32'd0);
        readReg(4'h4, rd);
        checkOutput("async_rst_status", rd, 32'h0000_0004);
        @(negedge clk);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1)
                saw_low = 1'b1;
        end
        checkOutput("no_frame_after_rst", 32'(saw_low), 32'd0);
        readReg(4'h4, rd);
        checkOutput("final_status", rd, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
